// File: rtl/fifo_skew_ctrl.sv
// Load-and-skew sequencer for the DIM transpose FIFOs ahead of the systolic array.
// Writes DIM rows one-hot into the FIFOs, then drains them with a one-cycle diagonal skew.
module fifo_skew_ctrl #(
  parameter int DIM  = 8,
  parameter int BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 row_valid,
  output logic                 row_ready,
  input  logic [DIM*BITS-1:0]  row_data,
  output logic [DIM-1:0]       wr_en,
  output logic [DIM*BITS-1:0]  wr_data,
  output logic [DIM-1:0]       shift_en,
  output logic                 busy,
  output logic                 done
);

  localparam int RCW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int DCW = ((2 * DIM - 1) > 1) ? $clog2(2 * DIM - 1) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [RCW-1:0] ROW_LAST   = RCW'(DIM - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * DIM - 2);

  logic [2:0]     state;
  logic [RCW-1:0] row_cnt;
  logic [DCW-1:0] drain_cnt;
  logic [31:0]    dcnt;
  logic           hs;
  logic [DIM-1:0] row_onehot;

  assign row_ready = (state == S_LOAD);
  assign hs        = row_valid & row_ready;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dcnt      = 32'(drain_cnt);

  always_comb begin
    row_onehot = '0;
    for (int unsigned k = 0; k < DIM; k++) begin
      if (row_cnt == RCW'(k)) row_onehot[k] = 1'b1;
    end
  end

  // FIFO i is active for the DIM drain steps starting at step i.
  always_comb begin
    shift_en = '0;
    if (state == S_DRAIN) begin
      for (int unsigned k = 0; k < DIM; k++) begin
        if ((dcnt >= k) && (dcnt <= k + 32'(DIM) - 32'd1)) shift_en[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      drain_cnt <= '0;
      wr_en     <= '0;
      wr_data   <= '0;
    end else begin
      wr_en <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_LOAD;
            row_cnt   <= '0;
            drain_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (hs) begin
            wr_en   <= row_onehot;
            wr_data <= row_data;
            if (row_cnt == ROW_LAST) state <= S_SETTLE;
            else                     row_cnt <= row_cnt + 1'b1;
          end
        end
        S_SETTLE: state <= S_DRAIN;
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= S_DONE;
          else                         drain_cnt <= drain_cnt + 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  a_wr_shift_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !((|wr_en) && (|shift_en)));

  a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

endmodule

// File: tb/tb_fifo_skew_ctrl.sv
// Directed table-driven bench for fifo_skew_ctrl (DIM=8, BITS=8).
module tb_fifo_skew_ctrl;

  typedef struct {
    logic        rst_n;
    logic        start;
    logic        row_valid;
    logic [63:0] row_data;
    logic        exp_ready;
    logic [7:0]  exp_wr_en;
    logic [63:0] exp_wr_data;
    logic [7:0]  exp_shift;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, row_valid;
  logic [63:0] row_data;
  logic        row_ready;
  logic [7:0]  wr_en;
  logic [63:0] wr_data;
  logic [7:0]  shift_en;
  logic        busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[28];
  int bitcnt[8];

  fifo_skew_ctrl #(.DIM(8), .BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .row_valid(row_valid),
    .row_ready(row_ready), .row_data(row_data), .wr_en(wr_en),
    .wr_data(wr_data), .shift_en(shift_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rowval(input int n);
    logic [7:0] b;
    b = 8'(n);
    return {8{b}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag, input bit count_bits);
    for (int t = 0; t < 28; t++) begin
      rst_n     = tbl[t].rst_n;
      start     = tbl[t].start;
      row_valid = tbl[t].row_valid;
      row_data  = tbl[t].row_data;
      #4;
      chk($sformatf("%s c%0d ready", tag, t),   {63'd0, row_ready}, {63'd0, tbl[t].exp_ready});
      chk($sformatf("%s c%0d wr_en", tag, t),   {56'd0, wr_en},     {56'd0, tbl[t].exp_wr_en});
      chk($sformatf("%s c%0d wr_data", tag, t), wr_data,            tbl[t].exp_wr_data);
      chk($sformatf("%s c%0d shift", tag, t),   {56'd0, shift_en},  {56'd0, tbl[t].exp_shift});
      chk($sformatf("%s c%0d busy", tag, t),    {63'd0, busy},      {63'd0, tbl[t].exp_busy});
      chk($sformatf("%s c%0d done", tag, t),    {63'd0, done},      {63'd0, tbl[t].exp_done});
      if (count_bits)
        for (int i = 0; i < 8; i++) if (shift_en[i]) bitcnt[i]++;
      next_cycle();
    end
  endtask

  initial begin
    int   hs_n, wr_n, last_hs, first_sh, done_n, done_at;
    logic prev_hs, this_hs, exp_ready;
    logic [63:0] prev_data;
    logic [7:0]  tmp;

    // Single fully-loaded pass: start at 0, rows at 1-8, drain 10-24, done 25.
    for (int t = 0; t < 28; t++) begin
      tbl[t].rst_n     = 1'b1;
      tbl[t].start     = (t == 0);
      tbl[t].row_valid = (t >= 1 && t <= 12);
      tbl[t].row_data  = (t >= 1 && t <= 8) ? rowval(t) : rowval(8'hE0 + t);
      tbl[t].exp_ready = (t >= 1 && t <= 8);
      tbl[t].exp_wr_en = (t >= 2 && t <= 9) ? 8'(1 << (t - 2)) : 8'h00;
      tbl[t].exp_wr_data = (t < 2) ? 64'd0 : (t <= 9) ? rowval(t - 1) : rowval(8);
      if (t >= 10 && t <= 17) tbl[t].exp_shift = 8'((1 << (t - 9)) - 1);
      else if (t >= 18 && t <= 24) begin
        tmp = 8'hFF;
        tbl[t].exp_shift = tmp << (t - 17);
      end else tbl[t].exp_shift = 8'h00;
      tbl[t].exp_busy = (t >= 1 && t <= 25);
      tbl[t].exp_done = (t == 25);
    end

    rst_n = 1'b0; start = 1'b0; row_valid = 1'b0; row_data = '0;
    next_cycle();
    next_cycle();
    #4;
    chk("reset ready",   {63'd0, row_ready}, 64'd0);
    chk("reset wr_en",   {56'd0, wr_en},     64'd0);
    chk("reset wr_data", wr_data,            64'd0);
    chk("reset shift",   {56'd0, shift_en},  64'd0);
    chk("reset busy",    {63'd0, busy},      64'd0);
    chk("reset done",    {63'd0, done},      64'd0);
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) bitcnt[i] = 0;
    run_table("pass1", 1'b1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("shift bit%0d count", i), 64'(bitcnt[i]), 64'd8);

    // Gapped row_valid with stray start pulses in LOAD (c4) and DRAIN (c20).
    hs_n = 0; wr_n = 0; last_hs = -1; first_sh = -1; done_n = 0; done_at = -1;
    prev_hs = 1'b0; prev_data = '0;
    for (int c = 0; c < 45; c++) begin
      start     = (c == 0 || c == 4 || c == 20);
      row_valid = (c >= 1 && c <= 15 && (c % 2 == 1));
      row_data  = rowval(8'h30 + c);
      #4;
      exp_ready = (c >= 1 && c <= 15);
      chk($sformatf("gap c%0d ready", c), {63'd0, row_ready}, {63'd0, exp_ready});
      chk($sformatf("gap c%0d wr_en", c), {56'd0, wr_en},
          prev_hs ? 64'(1 << (hs_n - 1)) : 64'd0);
      if (prev_hs) chk($sformatf("gap c%0d wr_data", c), wr_data, prev_data);
      if (wr_en != 8'h00) wr_n++;
      if (shift_en != 8'h00 && first_sh < 0) first_sh = c;
      if (done) begin done_n++; done_at = c; end
      this_hs = row_valid && exp_ready;
      if (this_hs) begin last_hs = c; hs_n++; prev_data = row_data; end
      prev_hs = this_hs;
      next_cycle();
    end
    chk("gap wr pulses",     64'(wr_n),     64'd8);
    chk("gap drain start",   64'(first_sh), 64'(last_hs + 2));
    chk("gap done count",    64'(done_n),   64'd1);
    chk("gap done cycle",    64'(done_at),  64'(last_hs + 17));
    #4;
    chk("gap busy after",    {63'd0, busy}, 64'd0);
    next_cycle();

    // Reset for one cycle at drain_cnt=5 (cycle 15), then a clean pass.
    for (int c = 0; c < 17; c++) begin
      start     = (c == 0);
      row_valid = (c >= 1 && c <= 8);
      row_data  = rowval(8'h40 + c);
      rst_n     = (c != 15);
      #4;
      if (c == 15) chk("midrst shift before", {56'd0, shift_en}, 64'h3F);
      if (c == 16) begin
        chk("midrst ready",   {63'd0, row_ready}, 64'd0);
        chk("midrst wr_en",   {56'd0, wr_en},     64'd0);
        chk("midrst wr_data", wr_data,            64'd0);
        chk("midrst shift",   {56'd0, shift_en},  64'd0);
        chk("midrst busy",    {63'd0, busy},      64'd0);
        chk("midrst done",    {63'd0, done},      64'd0);
      end
      if (c < 16) next_cycle();
    end
    rst_n = 1'b1; start = 1'b0; row_valid = 1'b0;
    next_cycle();
    run_table("pass2", 1'b0);

    // start and row_valid together in IDLE: that row is dropped.
    start = 1'b1; row_valid = 1'b1; row_data = rowval(8'hAA);
    #4;
    chk("same-cycle ready c0", {63'd0, row_ready}, 64'd0);
    next_cycle();
    start = 1'b0; row_data = rowval(8'hBB);
    #4;
    chk("same-cycle ready c1", {63'd0, row_ready}, 64'd1);
    chk("same-cycle busy c1",  {63'd0, busy},      64'd1);
    next_cycle();
    row_valid = 1'b0;
    #4;
    chk("same-cycle wr_en c2",   {56'd0, wr_en}, 64'h01);
    chk("same-cycle wr_data c2", wr_data,        rowval(8'hBB));
    next_cycle();
    #4;
    chk("same-cycle wr_en c3",   {56'd0, wr_en}, 64'h00);
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_skew_ctrl.md
# fifo_skew_ctrl

Load-and-skew sequencer that sits directly upstream of the bank of DIM transpose FIFOs feeding the systolic matrix-multiply array. It accepts DIM matrix rows over a valid/ready handshake and writes row k into FIFO k. It then issues per-FIFO shift enables with a one-cycle diagonal skew, so FIFO i starts draining i cycles after FIFO 0. It reports busy/done to the host-side MMIO control logic.

## Interface
- DIM, 8, matrix dimension: number of FIFOs, rows per load, and entries per FIFO.
- BITS, 8, element width.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk.
- start  in  1  begin a load/drain pass; honoured only in IDLE.
- row_valid  in  1  row_data carries a valid row.
- row_ready  out  1  block can accept a row this cycle.
- row_data  in  DIM*BITS  one matrix row, packed; element 0 in the MSBs [DIM*BITS-1 -: BITS].
- wr_en  out  DIM  one-hot write strobe; bit k drives FIFO k's write enable.
- wr_data  out  DIM*BITS  registered copy of the accepted row; shared by all FIFOs.
- shift_en  out  DIM  per-FIFO shift enable; bit i drives FIFO i's en.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse when a pass completes.

## Operation
- States: IDLE, LOAD, SETTLE, DRAIN, DONE.
- IDLE: if start=1, go to LOAD and clear row_cnt and drain_cnt. row_ready=0 in IDLE, so a row_valid in the same cycle as start is not accepted.
- LOAD: row_ready=1.
  - Handshake = row_valid & row_ready.
  - On a handshake, register row_data into wr_data and set wr_en = 1<<row_cnt for the next cycle only, then increment row_cnt.
  - Gaps in row_valid stall LOAD indefinitely. wr_en stays 0 during the gaps.
  - The handshake with row_cnt == DIM-1 moves the FSM to SETTLE.
- SETTLE: one cycle. The last write lands here. The FIFOs give write priority over shift, so no shift_en may be asserted in this cycle.
- DRAIN: drain_cnt runs from 0 to 2*DIM-2.
  - shift_en[i] = (drain_cnt >= i) && (drain_cnt <= i+DIM-1), decoded from registered state and drain_cnt.
  - Each FIFO receives exactly DIM shifts.
  - The consumer samples FIFO i's head in every cycle in which shift_en[i]=1.
  - At drain_cnt == 2*DIM-2, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored. It is not queued.
- row_cnt width: $clog2(DIM). drain_cnt width: $clog2(2*DIM-1). No counter wraps during a legal pass.
- wr_en and shift_en are never both nonzero in the same cycle.

## Timing
- Reset values: row_ready=0, wr_en=0, wr_data=0, shift_en=0, busy=0, done=0, state=IDLE, counters=0.
- A reset asserted mid-pass aborts the pass. Outputs return to the reset values on the next edge. The FIFO contents are not this block's responsibility.
- start at cycle t: busy=1 and row_ready=1 from t+1.
- Handshake at cycle t: wr_en[k] and wr_data are valid in cycle t+1 (1-cycle latency).
- Last handshake at t: SETTLE at t+1, DRAIN at t+2 through t+2*DIM, done pulse at t+2*DIM+1, IDLE (busy=0) at t+2*DIM+2.
- start sampled in the IDLE cycle directly after DONE begins a new pass.

## Test plan
- DIM=8, start at cycle 0, row_valid held high from cycle 1 with rows 0x0101..01 through 0x0808..08:
  - rows accepted at cycles 1-8;
  - wr_en = 0x01,0x02,...,0x80 at cycles 2-9 with matching wr_data;
  - SETTLE at 9, DRAIN at 10-24, done at 25, busy=0 at 26.
- Same load, drain pattern check:
  - shift_en = 0x01 at cycle 10, 0x03 at 11, ..., 0xFF at 17, 0xFE at 18, ..., 0x80 at 24;
  - each bit high for exactly 8 cycles.
- row_valid toggled 1,0,1,0 during LOAD: exactly 8 wr_en pulses, one per handshake; wr_en=0 in all gap cycles; DRAIN starts 2 cycles after the 8th handshake.
- start pulsed during LOAD and during DRAIN: no counter reset, no timing change; exactly one done pulse.
- rst_n=0 for one cycle at drain_cnt=5: next cycle all outputs are 0 and state is IDLE; a later start runs a full clean pass.
- start and row_valid asserted together in IDLE: that row is not accepted (row_ready=0); the first accepted row is the one presented in the following cycle.
